insn_encoder: RTL
=================

Name: insn_encoder

Overview:
- Inverse of the decode stage: takes decoded RISC-V RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, imm) and packs them into a 32-bit instruction word.
- Streams each legal encoded word into instruction memory at auto-incrementing addresses from BASE_ADDR.
- Serves as the program loader / self-test writer feeding fetch; round-trips with decode.
- Valid/ready on input, registered output stage with write backpressure, legality checking, and counters.

Parameters:
DWIDTH, 32, instruction/data width (only 32 supported)
AWIDTH, 32, memory address width
BASE_ADDR, 32'h0100_0000, first write address after reset or flush

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush_i  in  1  sync clear: address back to BASE_ADDR, drop held output
in_valid_i  in  1  field bundle valid
in_ready_o  out  1  encoder can accept a bundle this cycle
opcode_i  in  7  opcode
rd_i  in  5  destination register
rs1_i  in  5  source register 1
rs2_i  in  5  source register 2
funct3_i  in  3  funct3
funct7_i  in  7  funct7 (also selects SRLI/SRAI)
imm_i  in  32  signed immediate, byte offset for B/J, full upper value for U
mem_we_o  out  1  write request valid
mem_ready_i  in  1  memory accepts write this cycle
mem_addr_o  out  AWIDTH  write address
mem_data_o  out  32  encoded instruction
illegal_o  out  1  one-cycle pulse: accepted bundle rejected
written_cnt_o  out  16  words written, saturating
illegal_cnt_o  out  16  bundles rejected, saturating

Behaviour:
- Reset (rst=0, async): mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, illegal_o=0, both counters 0. in_ready_o is 1 after reset deasserts.
- Accept: when in_valid_i && in_ready_o.
- in_ready_o = !mem_we_o || mem_ready_i. This is a single output register with pass-through on drain, so full throughput with no bubbles.
- Latency: a bundle accepted in cycle N gives mem_we_o=1 with data in cycle N+1.
- While mem_we_o && !mem_ready_i, mem_addr_o and mem_data_o hold stable.
- Write completes when mem_we_o && mem_ready_i. On completion: mem_addr_o += 4 (mod 2^AWIDTH) and written_cnt_o += 1, saturating at 16'hFFFF.
- Formats (standard RV32I bit placement):
  - R: all fields.
  - I (ITYPE/LOAD/JALR): imm[11:0] in [31:20].
  - Shift-I (ITYPE with funct3 SLL or SRL_SRA): [31:25]=funct7_i, [24:20]=imm_i[4:0].
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B: imm[12|10:5] and imm[4:1|11].
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12].
  - Fields not used by a format are ignored.
- Illegal conditions (bundle is accepted, never written, address unchanged):
  - unknown opcode;
  - I/S imm outside -2048..2047;
  - B imm outside -4096..4094, or imm[0]=1;
  - J imm outside -2^20..2^20-2, or imm[0]=1;
  - U imm[11:0] != 0;
  - shift imm outside 0..31;
  - shift funct7 not in {0x00, 0x20}, or 0x20 used with SLL;
  - R funct7 not in {0x00, 0x20}.
- On an illegal bundle: illegal_o pulses in cycle N+1, illegal_cnt_o += 1 (saturating), output register untouched.
- flush_i (synchronous, highest priority):
  - next cycle mem_we_o=0 and mem_addr_o=BASE_ADDR;
  - in_ready_o is forced 0 during the flush cycle, so no accept;
  - counters are kept.
- Simultaneous completion and accept: address increments, then the new word is presented at the incremented address.
- Reset mid-write abandons the pending word.

Decomposition:
- Shared package, extending the existing constants header: opcode constants (RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), funct3/funct7 constants, and an insn_fmt_e enum {FMT_R, FMT_I, FMT_SHI, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}.
- One combinational sub-module, insn_pack, handles fields -> {word, illegal}. The top level holds the handshake, address register and counters.

Test Plan:
- ADDI x1,x0,5 (opcode 0x13, f3 0, imm 5) -> mem_data_o=0x00500093 at 0x01000000 one cycle after accept; written_cnt_o=1.
- ADD x3,x1,x2, then SW x2,8(x1), back-to-back with mem_ready_i=1 -> 0x002081B3 @0x01000000, 0x0020A423 @0x01000004, in_ready_o never drops.
- BEQ x1,x2,imm=-8 then JAL x1,imm=2048 -> 0xFE208CE3 and 0x001000EF.
- ADDI imm=2048, and BEQ imm=3 -> illegal_o pulse each, illegal_cnt_o=2, no mem_we_o, next legal word written at the unchanged address.
- mem_ready_i low for 3 cycles with a word pending -> addr/data stable, in_ready_o=0. On release, completion and the next accept happen in the same cycle.
- flush_i asserted while a write is pending, and separately async reset mid-stream -> mem_we_o=0, mem_addr_o=0x01000000. Counters are kept on flush and zeroed on reset.

Source files
------------

// File: rtl/insn_encoder_pkg.sv
// rtl/insn_encoder_pkg.sv - RV32I opcode/funct constants and instruction format classification
package insn_encoder_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SHI,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } insn_fmt_e;

    function automatic insn_fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
        insn_fmt_e fmt;
        case (opcode)
            OP_RTYPE:          fmt = FMT_R;
            OP_ITYPE:          fmt = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? FMT_SHI : FMT_I;
            OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_STORE:          fmt = FMT_S;
            OP_BRANCH:         fmt = FMT_B;
            OP_JAL:            fmt = FMT_J;
            OP_LUI, OP_AUIPC:  fmt = FMT_U;
            default:           fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    // True when v is representable as a signed value whose sign bit is v[msb].
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] hi;
        hi = $signed(v) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// rtl/insn_encoder_pack.sv - combinational field bundle to RV32I word packer with legality check
module insn_pack
    import insn_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    insn_fmt_e fmt;
    logic      f7_ok;

    always_comb begin
        fmt     = fmt_of(opcode, funct3);
        f7_ok   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word    = {funct7, rs2, rs1, funct3, rd, opcode};
                illegal = !f7_ok;
            end
            FMT_I: begin
                word    = {imm[11:0], rs1, funct3, rd, opcode};
                illegal = !fits_signed(imm, 11);
            end
            FMT_SHI: begin
                // funct7 travels in the upper bits; 0x20 selects SRAI and has no SLLI meaning
                word    = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                illegal = (imm[31:5] != '0) || !f7_ok
                          || (funct7 == F7_ALT && funct3 == F3_SLL);
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                illegal = !fits_signed(imm, 11);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = !fits_signed(imm, 12) || imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opcode};
                illegal = (imm[11:0] != '0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = !fits_signed(imm, 20) || imm[0];
            end
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - encodes RV32I field bundles and streams legal words into instruction memory
module insn_encoder #(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    input  logic              mem_ready_i,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              illegal_o,
    output logic [15:0]       written_cnt_o,
    output logic [15:0]       illegal_cnt_o
);

    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic              illegal_q;
    logic [15:0]       written_cnt_q;
    logic [15:0]       illegal_cnt_q;
    logic              accept;
    logic              complete;

    insn_pack u_pack (
        .opcode  (opcode_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .funct3  (funct3_i),
        .funct7  (funct7_i),
        .imm     (imm_i),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Single output register: a draining word frees the slot in the same cycle.
    assign in_ready_o = !flush_i && (!we_q || mem_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = we_q && mem_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q          <= 1'b0;
            addr_q        <= BASE_ADDR;
            data_q        <= '0;
            illegal_q     <= 1'b0;
            written_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q <= accept && pack_illegal;
            if (complete && written_cnt_q != 16'hFFFF) begin
                written_cnt_q <= written_cnt_q + 16'd1;
            end
            if (accept && pack_illegal && illegal_cnt_q != 16'hFFFF) begin
                illegal_cnt_q <= illegal_cnt_q + 16'd1;
            end
            if (flush_i) begin
                we_q   <= 1'b0;
                addr_q <= BASE_ADDR;
            end else begin
                if (complete) begin
                    addr_q <= addr_q + AWIDTH'(4);
                end
                if (accept && !pack_illegal) begin
                    we_q   <= 1'b1;
                    data_q <= DWIDTH'(pack_word);
                end else if (complete) begin
                    we_q <= 1'b0;
                end
            end
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_data_o    = data_q;
    assign illegal_o     = illegal_q;
    assign written_cnt_o = written_cnt_q;
    assign illegal_cnt_o = illegal_cnt_q;

endmodule
